mem_lsu: RTL and testbench

//  MEM stage. Sits between ex_mem and mem_wb, and feeds mem_wb's mem_wd/mem_wreg/mem_wdata/mem_hi/mem_lo/mem_whilo.
//  - Non-memory ops pass straight through.
//  - Loads/stores run a req/ack transaction on the data bus and stall the pipeline until ack or timeout.
//  - Handles byte-lane select, store replication, load extension, misalignment and bus timeout.

---
 rtl/mem_lsu_pkg.sv | 58 +++++
 rtl/lsu_align.sv | 58 +++++
 rtl/mem_lsu.sv | 191 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared constants and helpers for the MEM-stage load/store unit.
package mem_lsu_pkg;

  // Memory op codes (EXE_*_OP)
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  // Big-endian byte-lane selects
  localparam logic [3:0] DBUS_SEL_B0 = 4'b1000;
  localparam logic [3:0] DBUS_SEL_H0 = 4'b1100;
  localparam logic [3:0] DBUS_SEL_H1 = 4'b0011;
  localparam logic [3:0] DBUS_SEL_W  = 4'b1111;

  // FSM encodings
  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_BUSY = 2'd1;
  localparam logic [1:0] LSU_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    logic      is_signed;
    mem_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_mem_op(input logic [7:0] aluop);
    mem_op_t op;
    op = '0;
    case (aluop)
      EXE_LB_OP:  begin op.is_mem = 1'b1; op.is_load = 1'b1; op.is_signed = 1'b1; op.size = SZ_BYTE; end
      EXE_LBU_OP: begin op.is_mem = 1'b1; op.is_load = 1'b1; op.size = SZ_BYTE; end
      EXE_LH_OP:  begin op.is_mem = 1'b1; op.is_load = 1'b1; op.is_signed = 1'b1; op.size = SZ_HALF; end
      EXE_LHU_OP: begin op.is_mem = 1'b1; op.is_load = 1'b1; op.size = SZ_HALF; end
      EXE_LW_OP:  begin op.is_mem = 1'b1; op.is_load = 1'b1; op.size = SZ_WORD; end
      EXE_SB_OP:  begin op.is_mem = 1'b1; op.size = SZ_BYTE; end
      EXE_SH_OP:  begin op.is_mem = 1'b1; op.size = SZ_HALF; end
      EXE_SW_OP:  begin op.is_mem = 1'b1; op.size = SZ_WORD; end
      default:    op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte selects, store replication, load extension
// and misalignment detection for one memory op.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_src,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_load,
  output logic        misaligned,
  output logic [3:0]  sel,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  mem_op_t     op;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Decode op, pick the addressed lane and format both directions
  always_comb begin
    op         = decode_mem_op(aluop);
    is_mem     = op.is_mem;
    is_load    = op.is_load;
    misaligned = 1'b0;
    sel        = DBUS_SEL_W;
    store_data = store_src;
    load_data  = rdata;

    case (addr_lo)
      2'b00:   byte_v = rdata[31:24];
      2'b01:   byte_v = rdata[23:16];
      2'b10:   byte_v = rdata[15:8];
      default: byte_v = rdata[7:0];
    endcase
    half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    case (op.size)
      SZ_BYTE: begin
        sel        = DBUS_SEL_B0 >> addr_lo;
        store_data = {4{store_src[7:0]}};
        load_data  = op.is_signed ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      end
      SZ_HALF: begin
        sel        = addr_lo[1] ? DBUS_SEL_H1 : DBUS_SEL_H0;
        store_data = {2{store_src[15:0]}};
        load_data  = op.is_signed ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
        misaligned = op.is_mem & addr_lo[0];
      end
      default: begin
        misaligned = op.is_mem & (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage: pass-through for ALU results, req/ack data-bus transactions with
// pipeline stall, watchdog abort and misalignment reporting for loads/stores.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        whilo_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        stallreq_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        align_err_o,
  output logic        bus_err_o
);

  localparam logic             WDOG_EN       = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_MATCH = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       sel_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic             abort_q;

  logic             is_mem;
  logic             is_load;
  logic             misaligned;
  logic [3:0]       sel;
  logic [31:0]      store_data;
  logic [31:0]      load_data;

  // The pipeline is frozen while BUSY, so aluop_i/mem_addr_i still describe
  // the in-flight access when ack arrives and can drive load formatting.
  lsu_align u_align (
    .aluop      (aluop_i),
    .addr_lo    (mem_addr_i[1:0]),
    .store_src  (reg2_i),
    .rdata      (dbus_rdata_i),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .misaligned (misaligned),
    .sel        (sel),
    .store_data (store_data),
    .load_data  (load_data)
  );

  // Counter value after one more ack-less BUSY cycle; abort when it reaches the limit
  always_comb begin
    cnt_inc     = cnt + CNT_W'(1);
    timeout_hit = WDOG_EN && (cnt_inc == TIMEOUT_MATCH);
  end

  // FSM, watchdog counter and registered bus request
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state   <= LSU_IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= ZERO_WORD;
      sel_q   <= '0;
      wdata_q <= ZERO_WORD;
      rdata_q <= ZERO_WORD;
      abort_q <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (is_mem && !misaligned) begin
            req_q   <= 1'b1;
            we_q    <= ~is_load;
            addr_q  <= {mem_addr_i[31:2], 2'b00};
            sel_q   <= sel;
            wdata_q <= store_data;
            cnt     <= '0;
            abort_q <= 1'b0;
            state   <= LSU_BUSY;
          end
        end
        LSU_BUSY: begin
          if (dbus_ack_i) begin
            rdata_q <= load_data;
            req_q   <= 1'b0;
            state   <= LSU_DONE;
          end else if (timeout_hit) begin
            req_q   <= 1'b0;
            abort_q <= 1'b1;
            state   <= LSU_DONE;
          end else if (WDOG_EN) begin
            cnt <= cnt_inc;
          end
        end
        LSU_DONE: begin
          cnt     <= '0;
          abort_q <= 1'b0;
          state   <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

  // Outputs to mem_wb, stall request and error flags
  always_comb begin
    wd_o        = wd_i;
    wreg_o      = wreg_i;
    wdata_o     = wdata_i;
    hi_o        = hi_i;
    lo_o        = lo_i;
    whilo_o     = whilo_i;
    stallreq_o  = 1'b0;
    align_err_o = 1'b0;
    bus_err_o   = 1'b0;
    if (rst == RST_ENABLE) begin
      wd_o    = '0;
      wreg_o  = 1'b0;
      wdata_o = ZERO_WORD;
      hi_o    = ZERO_WORD;
      lo_o    = ZERO_WORD;
      whilo_o = 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (is_mem) begin
            wreg_o  = 1'b0;
            whilo_o = 1'b0;
            if (misaligned) align_err_o = 1'b1;
            else            stallreq_o  = 1'b1;
          end
        end
        LSU_BUSY: begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          whilo_o    = 1'b0;
        end
        LSU_DONE: begin
          whilo_o = 1'b0;
          if (abort_q) begin
            wreg_o    = 1'b0;
            bus_err_o = 1'b1;
          end else if (we_q) begin
            wreg_o = 1'b0;
          end else begin
            wdata_o = rdata_q;
          end
        end
        default: begin
          wreg_o  = 1'b0;
          whilo_o = 1'b0;
        end
      endcase
    end
  end

  // Bus outputs are forced low in the reset cycle, before the registers clear
  always_comb begin
    dbus_req_o   = req_q & ~rst;
    dbus_we_o    = we_q & ~rst;
    dbus_addr_o  = rst ? ZERO_WORD : addr_q;
    dbus_sel_o   = rst ? 4'b0000 : sel_q;
    dbus_wdata_o = rst ? ZERO_WORD : wdata_q;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed ops push expected mem_wb and bus
// records; two monitors pop and compare as the DUT retires ops / issues requests.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam logic [7:0]  OP_NOP  = 8'h00;
  localparam logic [7:0]  OP_ADDU = 8'b0010_0001;
  localparam logic [7:0]  OP_MTHI = 8'b0001_0001;
  localparam logic [31:0] HI_V    = 32'h0BAD_F00D;
  localparam logic [31:0] LO_V    = 32'h600D_CAFE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] hi_i = HI_V;
  logic [31:0] lo_i = LO_V;
  logic        whilo_i = 1'b0;
  logic [7:0]  aluop_i = OP_NOP;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] reg2_i = '0;
  logic        dbus_ack_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        stallreq_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_wdata_o;
  logic        align_err_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .aluop_i(aluop_i),
    .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o),
    .stallreq_o(stallreq_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
    .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    string       name;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        whilo;
    logic        aerr;
    logic        berr;
  } out_exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
    logic        chk_wdata;
    int unsigned cycles;
  } bus_exp_t;

  out_exp_t    out_q[$];
  bus_exp_t    bus_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        active = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_out(input string nm, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata, input logic chk_wdata,
                          input logic whilo, input logic aerr, input logic berr);
    out_exp_t e;
    e.name = nm; e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_wdata = chk_wdata;
    e.whilo = whilo; e.aerr = aerr; e.berr = berr;
    out_q.push_back(e);
  endtask

  task automatic push_bus(input string nm, input logic [31:0] addr, input logic [3:0] sel,
                          input logic we, input logic [31:0] wdata, input logic chk_wdata,
                          input int unsigned cycles);
    bus_exp_t b;
    b.name = nm; b.addr = addr; b.sel = sel; b.we = we; b.wdata = wdata;
    b.chk_wdata = chk_wdata; b.cycles = cycles;
    bus_q.push_back(b);
  endtask

  // mem_wb monitor: an op retires on the first non-stalled cycle it is presented
  initial begin
    out_exp_t e;
    forever begin
      @(negedge clk);
      if (active && !rst && !stallreq_o) begin
        if (out_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL out_unexpected: got retire with wd %h expected none", wd_o);
        end else begin
          e = out_q.pop_front();
          chk({e.name, "/wd_o"},        32'(wd_o),        32'(e.wd));
          chk({e.name, "/wreg_o"},      32'(wreg_o),      32'(e.wreg));
          if (e.chk_wdata) chk({e.name, "/wdata_o"}, wdata_o, e.wdata);
          chk({e.name, "/whilo_o"},     32'(whilo_o),     32'(e.whilo));
          chk({e.name, "/align_err_o"}, 32'(align_err_o), 32'(e.aerr));
          chk({e.name, "/bus_err_o"},   32'(bus_err_o),   32'(e.berr));
          chk({e.name, "/hi_o"},        hi_o,             HI_V);
          chk({e.name, "/lo_o"},        lo_o,             LO_V);
        end
      end
    end
  end

  // Bus monitor: check request fields on rise, stability and length on fall
  initial begin
    bus_exp_t    cur;
    logic        prev_req = 1'b0;
    logic        have_cur = 1'b0;
    logic        unstable = 1'b0;
    int unsigned blen = 0;
    logic [68:0] first_v = '0;
    forever begin
      @(negedge clk);
      if (dbus_req_o && !prev_req) begin
        first_v  = {dbus_addr_o, dbus_sel_o, dbus_we_o, dbus_wdata_o};
        blen     = 1;
        unstable = 1'b0;
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++; have_cur = 1'b0;
          $display("FAIL bus_unexpected: got req at addr %h expected no request", dbus_addr_o);
        end else begin
          cur = bus_q.pop_front();
          have_cur = 1'b1;
          chk({cur.name, "/dbus_addr_o"}, dbus_addr_o,     cur.addr);
          chk({cur.name, "/dbus_sel_o"},  32'(dbus_sel_o), 32'(cur.sel));
          chk({cur.name, "/dbus_we_o"},   32'(dbus_we_o),  32'(cur.we));
          if (cur.chk_wdata) chk({cur.name, "/dbus_wdata_o"}, dbus_wdata_o, cur.wdata);
        end
      end else if (dbus_req_o) begin
        blen++;
        if ({dbus_addr_o, dbus_sel_o, dbus_we_o, dbus_wdata_o} !== first_v) unstable = 1'b1;
      end else if (prev_req && have_cur) begin
        chk({cur.name, "/req_cycles"}, 32'(blen),     32'(cur.cycles));
        chk({cur.name, "/req_stable"}, 32'(unstable), 32'd0);
        have_cur = 1'b0;
      end
      prev_req = dbus_req_o;
    end
  end

  // Present one op (entered at posedge+1), feed ack ack_after BUSY cycles in
  // (-1 = never), hold until it retires, then check the stall length.
  task automatic run_op(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [4:0] wd, input logic wr,
                        input logic [31:0] wdat, input logic whl, input int ack_after,
                        input logic [31:0] rdata, input int unsigned exp_stall);
    int          c = 0;
    int unsigned stalls = 0;
    bit          done = 1'b0;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = wr;
    wdata_i = wdat; whilo_i = whl; dbus_ack_i = 1'b0; active = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (stallreq_o) stalls++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        c++;
        if (c > 40) begin
          n_cmp++; n_bad++;
          $display("FAIL %s/retire_timeout: got still stalled after %0d cycles expected retire", nm, c);
          done = 1'b1;
        end
        dbus_ack_i   = (ack_after >= 0) && (c == ack_after + 1);
        dbus_rdata_i = dbus_ack_i ? rdata : 32'h5A5A_5A5A;
      end
    end
    chk({nm, "/stall_cycles"}, 32'(stalls), 32'(exp_stall));
    @(posedge clk); #1;
    active = 1'b0; dbus_ack_i = 1'b0; aluop_i = OP_NOP; wreg_i = 1'b0; whilo_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    // Reset with live inputs: everything must be gated to 0
    aluop_i = OP_ADDU; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234; whilo_i = 1'b1;
    dbus_ack_i = 1'b1;
    @(negedge clk);
    chk("reset/wd_o",       32'(wd_o),       32'd0);
    chk("reset/wreg_o",     32'(wreg_o),     32'd0);
    chk("reset/wdata_o",    wdata_o,         32'd0);
    chk("reset/hi_lo",      hi_o | lo_o,     32'd0);
    chk("reset/whilo_o",    32'(whilo_o),    32'd0);
    chk("reset/stallreq_o", 32'(stallreq_o), 32'd0);
    chk("reset/dbus_req_o", 32'(dbus_req_o), 32'd0);
    chk("reset/errs",       32'({align_err_o, bus_err_o}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; dbus_ack_i = 1'b0; aluop_i = OP_NOP; wreg_i = 1'b0; whilo_i = 1'b0;
    @(posedge clk); #1;

    // Non-memory pass-through
    push_out("addu", 5'd3, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("addu", OP_ADDU, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 1'b0, -1, 32'h0, 0);
    push_out("mthi", 5'd0, 1'b0, 32'h0000_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("mthi", OP_MTHI, 32'h0, 32'h0, 5'd0, 1'b0, 32'hBEEF, 1'b1, -1, 32'h0, 0);

    // Loads
    push_bus("lb",  32'h0000_0100, 4'b0001, 1'b0, 32'h0, 1'b0, 1);
    push_out("lb",  5'd4, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("lb", EXE_LB_OP, 32'h0000_0103, 32'h0, 5'd4, 1'b1, 32'h0, 1'b0, 0, 32'h0000_00F0, 2);

    push_bus("lbu", 32'h0000_0100, 4'b0100, 1'b0, 32'h0, 1'b0, 1);
    push_out("lbu", 5'd5, 1'b1, 32'h0000_00F4, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("lbu", EXE_LBU_OP, 32'h0000_0101, 32'h0, 5'd5, 1'b1, 32'h0, 1'b0, 0, 32'h12F4_5678, 2);

    push_bus("lh",  32'h0000_0100, 4'b0011, 1'b0, 32'h0, 1'b0, 1);
    push_out("lh",  5'd6, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("lh", EXE_LH_OP, 32'h0000_0102, 32'h0, 5'd6, 1'b1, 32'h0, 1'b0, 0, 32'h1234_8001, 2);

    push_bus("lhu", 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 1'b0, 1);
    push_out("lhu", 5'd7, 1'b1, 32'h0000_8001, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("lhu", EXE_LHU_OP, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 32'h0, 1'b0, 0, 32'h8001_1234, 2);

    push_bus("lw",  32'h0000_0010, 4'b1111, 1'b0, 32'h0, 1'b0, 2);
    push_out("lw",  5'd8, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("lw", EXE_LW_OP, 32'h0000_0010, 32'h0, 5'd8, 1'b1, 32'h0, 1'b0, 1, 32'hDEAD_BEEF, 3);

    // Stores (SH ack lands on the watchdog's last cycle: ack must win)
    push_bus("sb",  32'h0000_0200, 4'b0100, 1'b1, 32'hABAB_ABAB, 1'b1, 1);
    push_out("sb",  5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sb", EXE_SB_OP, 32'h0000_0201, 32'h1234_56AB, 5'd9, 1'b1, 32'h0, 1'b0, 0, 32'h0, 2);

    push_bus("sh",  32'h0000_0200, 4'b0011, 1'b1, 32'h5678_5678, 1'b1, 4);
    push_out("sh",  5'd10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sh", EXE_SH_OP, 32'h0000_0202, 32'hAAAA_5678, 5'd10, 1'b1, 32'h0, 1'b0, 3, 32'h0, 5);

    push_bus("sw",  32'h0000_0204, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b1, 1);
    push_out("sw",  5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sw", EXE_SW_OP, 32'h0000_0204, 32'hCAFE_F00D, 5'd11, 1'b1, 32'h0, 1'b0, 0, 32'h0, 2);

    // Misaligned: no bus access, no stall
    push_out("lw_mis", 5'd12, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("lw_mis", EXE_LW_OP, 32'h0000_0006, 32'h0, 5'd12, 1'b1, 32'h0, 1'b0, 0, 32'h0, 0);
    chk("lw_mis/dbus_req_o", 32'(dbus_req_o), 32'd0);
    push_out("lh_mis", 5'd13, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("lh_mis", EXE_LH_OP, 32'h0000_0103, 32'h0, 5'd13, 1'b1, 32'h0, 1'b0, 0, 32'h0, 0);
    push_out("sh_mis", 5'd14, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sh_mis", EXE_SH_OP, 32'h0000_0201, 32'h1111_2222, 5'd14, 1'b1, 32'h0, 1'b0, 0, 32'h0, 0);
    chk("sh_mis/dbus_req_o", 32'(dbus_req_o), 32'd0);

    // Watchdog abort after 4 BUSY cycles
    push_bus("lw_to", 32'h0000_0040, 4'b1111, 1'b0, 32'h0, 1'b0, 4);
    push_out("lw_to", 5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("lw_to", EXE_LW_OP, 32'h0000_0040, 32'h0, 5'd15, 1'b1, 32'h0, 1'b0, -1, 32'h0, 5);
    chk("lw_to/bus_err_pulse", 32'(bus_err_o), 32'd0);

    // Reset in the 2nd BUSY cycle, then a stray ack
    push_bus("lw_rst", 32'h0000_0300, 4'b1111, 1'b0, 32'h0, 1'b0, 1);
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_0300; wd_i = 5'd9; wreg_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("lw_rst/wreg_o",     32'(wreg_o),     32'd0);
    chk("lw_rst/wd_o",       32'(wd_o),       32'd0);
    chk("lw_rst/stallreq_o", 32'(stallreq_o), 32'd0);
    chk("lw_rst/dbus_req_o", 32'(dbus_req_o), 32'd0);
    chk("lw_rst/dbus_bus",   dbus_addr_o | dbus_wdata_o | 32'(dbus_sel_o) | 32'(dbus_we_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; aluop_i = OP_NOP; wreg_i = 1'b0; dbus_ack_i = 1'b1; dbus_rdata_i = 32'h7777_7777;
    @(negedge clk);
    chk("stray_ack/wreg_o",     32'(wreg_o),     32'd0);
    chk("stray_ack/stallreq_o", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    dbus_ack_i = 1'b0;
    @(negedge clk);
    chk("stray_ack/wreg_o_next", 32'(wreg_o),     32'd0);
    chk("stray_ack/dbus_req_o",  32'(dbus_req_o), 32'd0);
    @(posedge clk); #1;
    push_out("addu_post", 5'd2, 1'b1, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("addu_post", OP_ADDU, 32'h0, 32'h0, 5'd2, 1'b1, 32'hAA, 1'b0, -1, 32'h0, 0);

    repeat (3) @(posedge clk);
    chk("end/out_q_empty", 32'(out_q.size()), 32'd0);
    chk("end/bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
